// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with mid-bit sampling, stop-bit check and a
// held-low (break) guard. Defining UART_RX_PARITY_EN switches the frame to
// 8E1 and adds the PARITY state and the parity_err strobe.
// The line passes a two-flop synchronizer plus one retiming flop (rx_s_q).
// As a result, the first edge that captures a falling rx is E0, and the FSM
// leaves IDLE at E3.
module uart_rx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       frame_err
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] CNT_ZERO      = {CW{1'b0}};

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

`ifdef UART_RX_PARITY_EN
  // Even parity bit for a byte: makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  logic [1:0]    sync_q, sync_d;
  logic          rx_s_q, rx_s_d;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          frame_err_q, frame_err_d;
  logic          frame_ok_s;
`ifdef UART_RX_PARITY_EN
  logic          parity_bad_q, parity_bad_d;
  logic          parity_err_q, parity_err_d;
`endif

  // Next-state logic: synchronizer shift, frame FSM, strobes and byte capture.
  always_comb begin
    sync_d      = {sync_q[0], rx};
    rx_s_d      = sync_q[1];
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_err_d = 1'b0;
    frame_ok_s   = !parity_bad_q;
`else
    frame_ok_s   = 1'b1;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!rx_s_q) begin
          state_d = ST_START;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d     = CNT_ZERO;
          bit_idx_d = 3'd0;
          if (!rx_s_q) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;  // glitch shorter than half a bit
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d     = CNT_ZERO;
          shift_d   = {rx_s_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d        = CNT_ZERO;
          parity_bad_d = (rx_s_q != even_parity(shift_q));
          state_d      = ST_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_BIT_LAST) begin
          cnt_d = CNT_ZERO;
`ifdef UART_RX_PARITY_EN
          parity_err_d = parity_bad_q;
`endif
          if (rx_s_q) begin
            state_d = ST_IDLE;
            if (frame_ok_s) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              valid_d = 1'b0;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = ST_WAIT_HIGH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_HIGH: begin
        if (rx_s_q) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset returns the line view to idle-high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b11;
      rx_s_q       <= 1'b1;
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      bit_idx_q    <= 3'd0;
      shift_q      <= 8'h00;
      data_q       <= 8'h00;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      frame_err_q  <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receiver that consumes the 8N1 frame produced by the UART transmit stage and returns it to a parallel byte. Sits directly downstream of the transmitter, on the far side of the serial line. It oversamples the asynchronous line, validates the start bit, samples each bit at mid-bit, checks the stop bit, and presents the byte with a one-cycle valid strobe.

## Interface
- CLKS_PER_BIT, 16, clk cycles per serial bit; integer, minimum 4; H = CLKS_PER_BIT/2 (integer division)
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- rx  input  1  serial line, idle high, asynchronous to clk
- data  output  8  last correctly framed byte, LSB received first
- valid  output  1  one-cycle strobe: data updated this cycle
- busy  output  1  high whenever FSM is not IDLE
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- parity_err  output  1  one-cycle strobe: parity mismatch (present only with UART_RX_PARITY_EN)

## Operation
- Reset values: data=8'h00, valid=0, busy=0, frame_err=0, parity_err=0, both synchronizer flops=1, FSM=IDLE, counters=0.
- rx passes through a two-flop synchronizer (rx_s); FSM sees only rx_s.
- States: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_HIGH.
- IDLE: rx_s==0 -> START, cnt=0.
- START: cnt counts to H-1; at cnt==H-1: rx_s==0 -> DATA, cnt=0, bit_idx=0; rx_s==1 -> IDLE (glitch rejected, no strobe).
- DATA: at cnt==CLKS_PER_BIT-1 sample rx_s into shift[7] with right shift (LSB first), cnt=0, bit_idx++; after 8th sample -> STOP (or PARITY).
- PARITY: at cnt==CLKS_PER_BIT-1 sample parity bit, compare with even parity of shift; go STOP.
- STOP: at cnt==CLKS_PER_BIT-1: rx_s==1 -> data<=shift, valid=1 (unless parity error), -> IDLE; rx_s==0 -> frame_err=1, data unchanged, valid=0, -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE. Prevents a held-low (break) line from producing repeated frames.
- Strobes are never asserted together with valid except none; valid and frame_err are mutually exclusive.
- Reset asserted mid-frame: everything returns to reset values immediately; partial byte discarded.

## Timing
- Let E0 be the first rising edge at which the first sync flop captures rx=0. FSM enters START at E3.
- Data bit i (0..7) sampled at edge E(3+H+(i+1)*CLKS_PER_BIT).
- Stop bit sampled at E(3+H+9*CLKS_PER_BIT); valid/frame_err high for exactly the following cycle. CLKS_PER_BIT=16: E155.
- With parity: parity sampled at E(3+H+9*CLKS_PER_BIT), stop at E(3+H+10*CLKS_PER_BIT).
- Next start bit accepted from the cycle after the stop sample; back-to-back frames with one stop bit are received without loss.
- busy rises at E3, falls with the stop-sample transition to IDLE.

## Configuration
- UART_RX_PARITY_EN defined: frame is 8E1; PARITY state and parity_err port present; parity mismatch pulses parity_err, suppresses valid, data unchanged, FSM still checks stop bit (frame_err may pulse the same cycle).
- Undefined: frame is 8N1; no PARITY state, no parity_err port.

## Test plan
- CLKS_PER_BIT=16, send 0xA5 8N1 -> data=0xA5, valid high one cycle at E155, frame_err=0.
- rx low for 4 cycles then high -> FSM returns IDLE from START, no valid, no frame_err.
- Send 0x3C with stop bit 0, hold rx low 40 bit times, release -> single frame_err pulse, no valid, data keeps previous value, no further strobes.
- Back-to-back 0x00 then 0xFF, one stop bit each -> two valid pulses exactly 10*CLKS_PER_BIT cycles apart, data 0x00 then 0xFF.
- Assert reset during bit 4 of 0x55, release, send 0x81 -> all outputs at reset values during reset; next valid carries 0x81.
- UART_RX_PARITY_EN defined, send 0x03 with parity bit 1 -> parity_err pulse, no valid; with parity bit 0 -> valid, data=0x03.
